// File: rtl/display_pkg.sv
// Shared encodings for the front-panel display controller: operating modes,
// named glyph codes and the BCD conversion state machine.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_RAW   = 2'd0,
    MODE_VALUE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // Glyph codes above 9 are the letters needed for panel status messages.
  localparam logic [3:0] G_E     = 4'hA;
  localparam logic [3:0] G_P     = 4'hB;
  localparam logic [3:0] G_N     = 4'hC;
  localparam logic [3:0] G_DASH  = 4'hD;
  localparam logic [3:0] G_R     = 4'hE;
  localparam logic [3:0] G_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Largest value that fits in the given number of decimal digits.
  function automatic logic [31:0] max_value(input int digits);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < digits; i++) r = r * 32'd10;
    return r - 32'd1;
  endfunction

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/glyph_to_seg.sv
// Combinational glyph decoder: 4-bit glyph code to {dp,g,f,e,d,c,b,a},
// segments active-high, decimal point passed straight through.
module glyph_to_seg
  import display_pkg::*;
(
  input  logic [3:0] glyph,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] segs;

  always_comb begin
    unique case (glyph)
      4'd0:    segs = 7'h3F;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5B;
      4'd3:    segs = 7'h4F;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6D;
      4'd6:    segs = 7'h7D;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7F;
      4'd9:    segs = 7'h6F;
      G_E:     segs = 7'h79;
      G_P:     segs = 7'h73;
      G_N:     segs = 7'h54;
      G_DASH:  segs = 7'h40;
      G_R:     segs = 7'h50;
      default: segs = 7'h00;
    endcase
  end

  assign seg = {dp, segs};

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment controller: scans NUM_DIGITS digits showing either raw
// glyphs or a binary cents value converted to BCD by a serial double-dabble.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 10,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64,
  parameter int DP_POS      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] glyphs,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load_val,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [31:0] MAX_VAL = max_value(NUM_DIGITS);

  // ---------------------------------------------------------------------------
  // Refresh prescaler, digit index and blink phase
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_hidden;

  assign tick = (presc == PRE_W'(REFRESH_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
          blink_cnt    <= '0;
          blink_hidden <= ~blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serial double-dabble conversion
  // ---------------------------------------------------------------------------
  conv_state_e        state, state_nx;
  logic [VALUE_W-1:0] bin_q;
  logic [BCD_W-1:0]   scr_q, scr_adj;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every signal gets a default before the case so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (load_val) state_nx = ST_SHIFT;
      ST_SHIFT:  if (cnt == CNT_W'(VALUE_W - 1)) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_COMMIT);

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < NUM_DIGITS; i++) scr_adj[4*i +: 4] = add3(scr_q[4*i +: 4]);
  end

  // NOTE: the scratch shift registers carry no reset; they are fully reloaded
  // on capture and never observed before that.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && load_val) begin
      bin_q <= value;
      scr_q <= '0;
    end else if (state == ST_SHIFT) begin
      {scr_q, bin_q} <= {scr_adj[BCD_W-2:0], bin_q, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (load_val) begin
          cnt      <= '0;
          ovf_pend <= (32'(value) > MAX_VAL);
        end
        ST_SHIFT:  cnt <= cnt + 1'b1;
        ST_COMMIT: begin
          bcd_q <= scr_q;
          ovf_q <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Digit content selection and registered pin drivers
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] blank_lz;
  logic                  zero_above;
  logic [3:0]            glyph_cur;
  logic                  dp_cur, show, en;
  logic [NUM_DIGITS-1:0] onehot;
  logic [7:0]            seg_nx;

  // A digit left of the decimal point is blank when it and everything above it is zero.
  always_comb begin
    blank_lz   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (bcd_q[4*i +: 4] == 4'd0);
      blank_lz[i] = zero_above & (i > DP_POS);
    end
  end

  always_comb begin
    glyph_cur = G_BLANK;
    dp_cur    = 1'b0;
    show      = 1'b1;
    en        = 1'b1;
    unique case (mode_e'(mode))
      MODE_RAW, MODE_BLINK: begin
        glyph_cur = glyphs[{idx, 2'b00} +: 4];
        dp_cur    = dp_in[idx];
        if (mode_e'(mode) == MODE_BLINK && blink_hidden) show = 1'b0;
      end
      MODE_VALUE: begin
        if (ovf_q) begin
          glyph_cur = G_DASH;
        end else begin
          glyph_cur = blank_lz[idx] ? G_BLANK : bcd_q[{idx, 2'b00} +: 4];
          dp_cur    = (int'(idx) == DP_POS);
        end
      end
      MODE_BLANK: begin
        show = 1'b0;
        en   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  glyph_to_seg u_glyph_to_seg (
    .glyph (glyph_cur),
    .dp    (dp_cur),
    .seg   (seg_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= '0;
      dig_en <= '0;
    end else begin
      seg    <= show ? seg_nx : 8'h00;
      dig_en <= en ? onehot : '0;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a 4-digit and a 3-digit instance share
// stimulus so range and overflow behaviour are seen side by side.
module tb_display_scan_ctrl;

  localparam logic [7:0] S0 = 8'h3F, S1 = 8'h06, S2 = 8'h5B, S3 = 8'h4F;
  localparam logic [7:0] S4 = 8'h66, S5 = 8'h6D, S7 = 8'h07;
  localparam logic [7:0] SE = 8'h79, SN = 8'h54, SR = 8'h50, SD = 8'h40;
  localparam logic [7:0] SB = 8'h00, DP = 8'h80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] glyphs;
  logic [3:0]  dp_in;
  logic [9:0]  value;
  logic        load_val;

  logic       busy4, done4, busy3, done3;
  logic [7:0] seg4, seg3;
  logic [3:0] dig_en4;
  logic [2:0] dig_en3;

  int errors = 0;
  int checks = 0;

  logic [7:0] f4 [4];
  logic [7:0] f3 [3];

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS(4), .VALUE_W(10), .REFRESH_DIV(4), .BLINK_DIV(2), .DP_POS(2)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .glyphs(glyphs), .dp_in(dp_in),
    .value(value), .load_val(load_val), .busy(busy4), .done(done4),
    .seg(seg4), .dig_en(dig_en4)
  );

  display_scan_ctrl #(
    .NUM_DIGITS(3), .VALUE_W(10), .REFRESH_DIV(4), .BLINK_DIV(2), .DP_POS(2)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .glyphs(glyphs[11:0]), .dp_in(dp_in[2:0]),
    .value(value), .load_val(load_val), .busy(busy3), .done(done3),
    .seg(seg3), .dig_en(dig_en3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Watch a few full scan frames and remember what each digit showed last.
  task automatic sample_frame();
    for (int i = 0; i < 4; i++) f4[i] = 8'hFF;
    for (int i = 0; i < 3; i++) f3[i] = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (dig_en4 == 4'(1 << i)) f4[i] = seg4;
      for (int i = 0; i < 3; i++) if (dig_en3 == 3'(1 << i)) f3[i] = seg3;
    end
  endtask

  task automatic check4(input string tag, input logic [7:0] e3, e2, e1, e0);
    check({tag, "_n4_d3"}, 32'(f4[3]), 32'(e3));
    check({tag, "_n4_d2"}, 32'(f4[2]), 32'(e2));
    check({tag, "_n4_d1"}, 32'(f4[1]), 32'(e1));
    check({tag, "_n4_d0"}, 32'(f4[0]), 32'(e0));
  endtask

  task automatic check3(input string tag, input logic [7:0] e2, e1, e0);
    check({tag, "_n3_d2"}, 32'(f3[2]), 32'(e2));
    check({tag, "_n3_d1"}, 32'(f3[1]), 32'(e1));
    check({tag, "_n3_d0"}, 32'(f3[0]), 32'(e0));
  endtask

  // Pulse load_val and watch 20 cycles; optionally retrigger while busy.
  task automatic do_load(input string tag, input logic [9:0] v, input bit timing, input bit reload);
    int busy_n, done_n, done3_n, done_at;
    busy_n = 0; done_n = 0; done3_n = 0; done_at = 0;
    @(negedge clk);
    value    = v;
    load_val = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      load_val = 1'b0;
      if (reload && i == 3) begin
        value    = 10'd999;
        load_val = 1'b1;
      end
      if (busy4) busy_n++;
      if (done4) begin
        done_n++;
        done_at = i;
      end
      if (done3) done3_n++;
    end
    if (timing) begin
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
      check({tag, "_done_at"}, 32'(done_at), 32'd11);
    end
    check({tag, "_done_pulses_n4"}, 32'(done_n), 32'd1);
    check({tag, "_done_pulses_n3"}, 32'(done3_n), 32'd1);
  endtask

  initial begin
    logic [3:0] de [18];
    int hidden_n, scan_n, run, max_run, blank_bad;

    rst_n = 1'b0; mode = 2'd0; glyphs = 16'hA404; dp_in = 4'b0000;
    value = '0; load_val = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg4), 32'h0);
    check("rst_dig_en", 32'(dig_en4), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_done", 32'(done4), 32'h0);
    check("rst_dig_en_n3", 32'(dig_en3), 32'h0);

    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      de[n] = dig_en4;
    end
    check("scan_c1", 32'(de[1]), 32'h1);
    check("scan_c4", 32'(de[4]), 32'h1);
    check("scan_c5", 32'(de[5]), 32'h2);
    check("scan_c9", 32'(de[9]), 32'h4);
    check("scan_c13", 32'(de[13]), 32'h8);
    check("scan_c17", 32'(de[17]), 32'h1);

    sample_frame();
    check4("raw_E404", SE, S4, S0, S4);

    glyphs = 16'hEDCF; dp_in = 4'b0101;
    sample_frame();
    check4("raw_letters", SR, SD | DP, SN, SB | DP);

    mode = 2'd1;
    do_load("v175", 10'd175, 1'b1, 1'b0);
    sample_frame();
    check4("v175", SB, S1 | DP, S7, S5);
    check3("v175", S1 | DP, S7, S5);

    do_load("v25", 10'd25, 1'b0, 1'b1);
    sample_frame();
    check4("v25", SB, S0 | DP, S2, S5);
    check3("v25", S0 | DP, S2, S5);

    do_load("v1023", 10'd1023, 1'b0, 1'b0);
    sample_frame();
    check4("v1023", S1, S0 | DP, S2, S3);
    check3("v1023_ovf", SD, SD, SD);

    do_load("v100", 10'd100, 1'b0, 1'b0);
    sample_frame();
    check4("v100", SB, S1 | DP, S0, S0);
    check3("v100", S1 | DP, S0, S0);

    mode = 2'd2; glyphs = 16'h0BAC; dp_in = 4'b0000;
    repeat (2) @(negedge clk);
    hidden_n = 0; scan_n = 0; run = 0; max_run = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (dig_en4 != 4'h0) scan_n++;
      if (seg4 == 8'h00) begin
        hidden_n++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("blink_hidden_cycles", 32'(hidden_n), 32'd32);
    check("blink_scanning", 32'(scan_n), 32'd64);
    check("blink_hidden_run", 32'(max_run), 32'd8);

    mode = 2'd3;
    @(negedge clk);
    blank_bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (dig_en4 != 4'h0 || seg4 != 8'h00 || dig_en3 != 3'h0) blank_bad++;
    end
    check("blank_outputs", 32'(blank_bad), 32'd0);

    mode = 2'd1;
    @(negedge clk);
    value = 10'd555; load_val = 1'b1;
    @(negedge clk);
    load_val = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_busy", 32'(busy4), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy4), 32'h0);
    check("async_rst_seg", 32'(seg4), 32'h0);
    check("async_rst_dig_en", 32'(dig_en4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sample_frame();
    check4("post_rst", SB, S0 | DP, S0, S0);
    check3("post_rst", S0 | DP, S0, S0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
